// File: rtl/pdm_mic_capture_ctrl.sv
// pdm_mic_capture_ctrl: PDM microphone capture sequencer.
// Divides mclk down to mic_clk, runs IDLE/WARMUP/CAPTURE, and turns each
// window of PDM bits into a ones-count PCM sample behind a valid/ready port
// with sticky overrun. Define MIC_STEREO_EN to also sample mic_data on the
// falling edge into a right-channel accumulator with a 2-deep output.
module pdm_mic_capture_ctrl #(
  parameter int CLK_DIV     = 25,
  parameter int WINDOW      = 64,
  parameter int WARMUP_BITS = 16,
  localparam int CNT_W      = $clog2(WINDOW + 1)
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             mic_clk,
  output logic             mic_lrsel,
  input  logic             mic_data,
  output logic [CNT_W-1:0] sample,
  output logic             sample_ch,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WARM_W = $clog2(WARMUP_BITS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mic_clk_q, mic_clk_d;
  logic [WARM_W-1:0]  warm_q;
  logic [CNT_W-1:0]   bit_q;
  logic [CNT_W-1:0]   ones_l_q;
  logic               stop_pend_q;
  logic               overrun_q;

  logic               div_wrap;
  logic               rise_tick;
  logic               start_acc;
  logic               win_end;
  logic               load;
  logic [CNT_W-1:0]   sum_l;

  assign div_wrap  = (div_q == DIV_LAST);
  assign rise_tick = (state_q != S_IDLE) && div_wrap && !mic_clk_q;
  assign start_acc = (state_q == S_IDLE) && start;
  assign win_end   = (state_q == S_CAPTURE) && rise_tick && (bit_q == WIN_LAST);
  // The window's last bit is folded in directly rather than waiting a cycle.
  assign sum_l     = ones_l_q + CNT_W'(mic_data);

  assign mic_clk   = mic_clk_q;
  assign mic_lrsel = 1'b0;
  assign overrun   = overrun_q;

  // State register.
  always_ff @(posedge mclk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start beats a simultaneous stop in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_WARMUP;
      S_WARMUP: begin
        if (stop)                                  state_d = S_IDLE;
        else if (rise_tick && warm_q == WARM_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: if (win_end && (stop_pend_q || stop)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Divider next state: held cleared in IDLE and on the way into IDLE so
  // mic_clk is parked low the moment capture ends.
  always_comb begin
    div_d     = div_q + DIV_W'(1);
    mic_clk_d = mic_clk_q;
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      div_d     = '0;
      mic_clk_d = 1'b0;
    end else if (div_wrap) begin
      div_d     = '0;
      mic_clk_d = ~mic_clk_q;
    end
  end

  // Divider registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      div_q     <= '0;
      mic_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      mic_clk_q <= mic_clk_d;
    end
  end

  // Warm-up bit counter, counts discarded rise ticks.
  always_ff @(posedge mclk) begin
    if (reset || state_q != S_WARMUP) warm_q <= '0;
    else if (rise_tick)               warm_q <= warm_q + WARM_W'(1);
  end

  // Left accumulator: bit position and ones count within the window.
  always_ff @(posedge mclk) begin
    if (reset || state_q != S_CAPTURE) begin
      bit_q    <= '0;
      ones_l_q <= '0;
    end else if (rise_tick) begin
      if (bit_q == WIN_LAST) begin
        bit_q    <= '0;
        ones_l_q <= '0;
      end else begin
        bit_q    <= bit_q + CNT_W'(1);
        ones_l_q <= sum_l;
      end
    end
  end

  // Stop request remembered until the running window finishes.
  always_ff @(posedge mclk) begin
    if (reset || state_q != S_CAPTURE) stop_pend_q <= 1'b0;
    else if (stop)                     stop_pend_q <= 1'b1;
  end

  // Sticky overrun, cleared only by reset or an accepted start.
  always_ff @(posedge mclk) begin
    if (reset)                 overrun_q <= 1'b0;
    else if (start_acc)        overrun_q <= 1'b0;
    else if (win_end && !load) overrun_q <= 1'b1;
  end

`ifdef MIC_STEREO_EN
  logic             fall_tick;
  logic [CNT_W-1:0] ones_r_q;
  logic [CNT_W-1:0] sample_l_q, sample_r_q;
  logic             valid_l_q, valid_r_q;
  logic             show_r;

  assign fall_tick = (state_q != S_IDLE) && div_wrap && mic_clk_q;
  // Both entries must be free; the right entry may free up this very cycle.
  assign load      = win_end && !valid_l_q && (!valid_r_q || sample_ready);
  assign show_r    = !valid_l_q && valid_r_q;

  assign sample       = show_r ? sample_r_q : sample_l_q;
  assign sample_ch    = show_r;
  assign sample_valid = valid_l_q || valid_r_q;

  // Right accumulator; its window closes on the left channel's boundary.
  always_ff @(posedge mclk) begin
    if (reset || state_q != S_CAPTURE) ones_r_q <= '0;
    else if (win_end)                  ones_r_q <= '0;
    else if (fall_tick)                ones_r_q <= ones_r_q + CNT_W'(mic_data);
  end

  // Two-entry output: left presents first, right after left is taken.
  always_ff @(posedge mclk) begin
    if (reset) begin
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_l_q  <= 1'b0;
      valid_r_q  <= 1'b0;
    end else if (load) begin
      sample_l_q <= sum_l;
      sample_r_q <= ones_r_q;
      valid_l_q  <= 1'b1;
      valid_r_q  <= 1'b1;
    end else if (valid_l_q) begin
      if (sample_ready) valid_l_q <= 1'b0;
    end else if (valid_r_q && sample_ready) begin
      valid_r_q <= 1'b0;
    end
  end
`else
  logic [CNT_W-1:0] sample_l_q;
  logic             valid_l_q;

  assign load         = win_end && (!valid_l_q || sample_ready);
  assign sample       = sample_l_q;
  assign sample_ch    = 1'b0;
  assign sample_valid = valid_l_q;

  // Single-entry output register; held stable until accepted.
  always_ff @(posedge mclk) begin
    if (reset) begin
      sample_l_q <= '0;
      valid_l_q  <= 1'b0;
    end else if (load) begin
      sample_l_q <= sum_l;
      valid_l_q  <= 1'b1;
    end else if (valid_l_q && sample_ready) begin
      valid_l_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pdm_mic_capture_ctrl.sv
// Bench for pdm_mic_capture_ctrl with CLK_DIV=2, WINDOW=8, WARMUP_BITS=2.
// Stimulus pushes expected samples into a queue; a negedge monitor pops and
// compares whenever the DUT hands over a sample. Honors MIC_STEREO_EN.
`timescale 1ns/1ps
module tb_pdm_mic_capture_ctrl;
  localparam int CD  = 2;
  localparam int WIN = 8;
  localparam int WB  = 2;
  localparam int CW  = $clog2(WIN + 1);

  logic          mclk = 1'b0;
  logic          reset, start, stop, sample_ready;
  logic          mic_data;
  logic          mic_clk, mic_lrsel, sample_ch, sample_valid, busy, overrun;
  logic [CW-1:0] sample;

  always #5 mclk = ~mclk;

  pdm_mic_capture_ctrl #(.CLK_DIV(CD), .WINDOW(WIN), .WARMUP_BITS(WB)) dut (
    .mclk(mclk), .reset(reset), .start(start), .stop(stop),
    .mic_clk(mic_clk), .mic_lrsel(mic_lrsel), .mic_data(mic_data),
    .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .overrun(overrun)
  );

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // mic_data source: 0 const0, 1 const1, 2 alternate per rise tick, 3 ~mic_clk
  int   data_mode = 1;
  logic alt_q = 1'b0;
  always @(posedge mic_clk) alt_q <= ~alt_q;
  assign mic_data = (data_mode == 0) ? 1'b0 :
                    (data_mode == 1) ? 1'b1 :
                    (data_mode == 2) ? alt_q : ~mic_clk;

  typedef struct {
    int val;
    int ch;
    int at_cyc;   // -1: cycle not checked
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
    end
  endfunction

  function automatic void expect_win(input int lv, input int rv, input int c);
    exp_t e;
    e.val = lv; e.ch = 0; e.at_cyc = c;
    exp_q.push_back(e);
`ifdef MIC_STEREO_EN
    e.val = rv; e.ch = 1; e.at_cyc = (c < 0) ? -1 : c + 1;
    exp_q.push_back(e);
`else
    if (rv < 0) $display("[TB] note: negative right value ignored");
`endif
  endfunction

  // Monitor: compare held value every cycle, pop on transfer.
  always @(negedge mclk) begin
    if (!reset && sample_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", int'(sample_valid), 0);
      end else begin
        mon_e = exp_q[0];
        chk("sample_value", int'(sample), mon_e.val);
        if (sample_ready) begin
          chk("sample_ch", int'(sample_ch), mon_e.ch);
          if (mon_e.at_cyc >= 0) chk("sample_cycle", cyc, mon_e.at_cyc);
          $display("[TB] sample accepted cyc=%0d value=%0d ch=%0d", cyc, sample, sample_ch);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge mclk); #1;
  endtask

  task automatic go_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic at_neg(input int c);
    go_cyc(c);
    @(negedge mclk);
  endtask

  task automatic pulse_start(output int s);
    s = cyc; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop_at(input int c);
    go_cyc(c); stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mic_clk"}, int'(mic_clk), 0);
    chk({tag, "_mic_lrsel"}, int'(mic_lrsel), 0);
    chk({tag, "_sample"}, int'(sample), 0);
    chk({tag, "_sample_ch"}, int'(sample_ch), 0);
    chk({tag, "_sample_valid"}, int'(sample_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  int s;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    at_neg(cyc);
    check_reset_values("reset");

    // stop while idle is ignored
    pulse_stop_at(cyc + 1);
    at_neg(cyc + 1);
    chk("stop_in_idle_busy", int'(busy), 0);

    // A: all-ones, four windows, stray start ignored, stop during last window
    data_mode = 1; sample_ready = 1'b1;
    go_cyc(cyc + 2);
    pulse_start(s);
    expect_win(8, 8, s + 39);
    expect_win(8, 8, s + 71);
    expect_win(8, 8, s + 103);
    expect_win(8, 8, s + 135);
    for (int c = s + 1; c <= s + 8; c++) begin
      at_neg(c);
      if (c == s + 1) chk("busy_after_start", int'(busy), 1);
      chk("mic_clk_wave", int'(mic_clk), ((c - s - 1) / 2) % 2);
    end
    go_cyc(s + 20); start = 1'b1; step(); start = 1'b0;
    pulse_stop_at(s + 115);
    at_neg(s + 134);
    chk("busy_before_final_end", int'(busy), 1);
    at_neg(s + 135);
    chk("busy_after_final_end", int'(busy), 0);
    chk("mic_clk_parked", int'(mic_clk), 0);
    at_neg(s + 140);
    chk("mic_clk_parked_later", int'(mic_clk), 0);
    chk("no_overrun_a", int'(overrun), 0);

    // B: alternating bits, start+stop together in idle (start wins)
    data_mode = 2;
    go_cyc(cyc + 2);
    s = cyc; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    expect_win(4, 4, s + 39);
    expect_win(4, 4, s + 71);
    at_neg(s + 1);
    chk("start_wins_busy", int'(busy), 1);
    pulse_stop_at(s + 55);
    at_neg(s + 71);
    chk("busy_after_b", int'(busy), 0);

    // C: all zeros, stop at bit 3 of the first window
    data_mode = 0;
    go_cyc(cyc + 2);
    pulse_start(s);
    expect_win(0, 0, s + 39);
    pulse_stop_at(s + 19);
    at_neg(s + 40);
    chk("busy_after_c", int'(busy), 0);

    // D: consumer stalls across two window ends -> held sample, overrun
    data_mode = 1; sample_ready = 1'b0;
    go_cyc(cyc + 2);
    pulse_start(s);
    expect_win(8, 8, -1);
    at_neg(s + 60);
    chk("overrun_after_one_window", int'(overrun), 0);
    at_neg(s + 75);
    chk("overrun_after_drop", int'(overrun), 1);
    chk("valid_held", int'(sample_valid), 1);
    pulse_stop_at(s + 80);
    go_cyc(s + 110); sample_ready = 1'b1;
    at_neg(s + 115);
    chk("overrun_sticky", int'(overrun), 1);
    chk("valid_drained", int'(sample_valid), 0);
    chk("busy_after_d", int'(busy), 0);

    // E: accepted start clears overrun; reset mid-window aborts; fresh run
    go_cyc(cyc + 2);
    s = cyc; start = 1'b1;
    at_neg(s);
    chk("overrun_before_start_edge", int'(overrun), 1);
    go_cyc(s + 1); start = 1'b0;
    at_neg(s + 1);
    chk("overrun_cleared_by_start", int'(overrun), 0);
    go_cyc(s + 25); reset = 1'b1;
    go_cyc(s + 26); reset = 1'b0;
    at_neg(s + 26);
    check_reset_values("midreset");
    go_cyc(cyc + 2);
    pulse_start(s);
    expect_win(8, 8, s + 39);
    pulse_stop_at(s + 19);
    at_neg(s + 40);
    chk("busy_after_e", int'(busy), 0);

    // F: stop during warm-up -> idle next cycle, no sample
    go_cyc(cyc + 2);
    pulse_start(s);
    go_cyc(s + 3); stop = 1'b1;
    at_neg(s + 3);
    chk("busy_in_warmup", int'(busy), 1);
    go_cyc(s + 4); stop = 1'b0;
    at_neg(s + 4);
    chk("busy_after_warmup_stop", int'(busy), 0);
    chk("mic_clk_after_warmup_stop", int'(mic_clk), 0);
    go_cyc(s + 60);

`ifdef MIC_STEREO_EN
    // G: ones while mic_clk low, zeros while high -> left 8 then right 0
    data_mode = 3;
    go_cyc(cyc + 2);
    pulse_start(s);
    expect_win(8, 0, s + 39);
    pulse_stop_at(s + 19);
    at_neg(s + 45);
    chk("busy_after_stereo", int'(busy), 0);
`endif

    at_neg(cyc + 5);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
